// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - five-stage RISC-V hazard controller: forwarding, stalls, flushes
// and the write-back control shadow pipeline with stall/flush event counters.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic [4:0]       RSD1_E,
    input  logic [4:0]       RSD2_E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    logic       RegWriteE;
    logic       RegWriteM;
    logic [1:0] ResultSrcE;
    logic [1:0] ResultSrcM;
    logic       lw_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       rw_m,
        input logic [4:0] rd_w,
        input logic       rw_w
    );
        if (rs != 5'd0 && rs == rd_m && rw_m)
            return 2'b10;
        else if (rs != 5'd0 && rs == rd_w && rw_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    // Reset forces a clean pipeline: everything flushed, nothing stalled or forwarded.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            StallF    = lw_stall && !PCSrcE;
            StallD    = lw_stall && !PCSrcE;
            FlushD    = PCSrcE;
            FlushE    = lw_stall || PCSrcE;
            ForwardAE = fwd_sel(RSD1_E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(RSD2_E, RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteE  <= 1'b0;
            ResultSrcE <= 2'b00;
            RegWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            StallCnt   <= '0;
            FlushCnt   <= '0;
        end else begin
            RegWriteE  <= FlushE ? 1'b0 : RegWriteD;
            ResultSrcE <= FlushE ? 2'b00 : ResultSrcD;
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            StallCnt   <= StallCnt + {{(CNT_W-1){1'b0}}, StallF};
            FlushCnt   <= FlushCnt + {{(CNT_W-1){1'b0}}, PCSrcE};
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed checks of hazard_unit against a stage-list model
module tb_hazard_unit;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    logic             clk;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, RSD1_E, RSD2_E, RdE, RdM, RdW;
    logic             RegWriteD, PCSrcE;
    logic [1:0]       ResultSrcD;
    logic [1:0]       ForwardAE, ForwardBE, ResultSrcW;
    logic             StallF, StallD, FlushD, FlushE, RegWriteW;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int n_pass;
    int n_total;

    // Model: control bits of the instructions currently in E, M, W (index 0, 1, 2).
    int m_rw[3];
    int m_rs[3];
    int m_stall_cnt;
    int m_flush_cnt;
    int exp_stall;
    int exp_flush_e;
    int cnt_before;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .RSD1_E(RSD1_E), .RSD2_E(RSD2_E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int fwd(input int rs);
        if (rs != 0 && rs == int'(RdM) && m_rw[1] == 1) return 2;
        if (rs != 0 && rs == int'(RdW) && m_rw[2] == 1) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; RSD1_E = 0; RSD2_E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteD = 0; ResultSrcD = 0; PCSrcE = 0;
    endtask

    task automatic eval_check();
        int lw;
        #1;
        lw = (m_rw[0] == 1 && m_rs[0] == 1 && RdE != 0 &&
              (Rs1D == RdE || Rs2D == RdE)) ? 1 : 0;
        if (reset) begin
            exp_stall = 0;
            exp_flush_e = 1;
            check("fwd_a", ForwardAE, 0);
            check("fwd_b", ForwardBE, 0);
            check("flush_d", FlushD, 1);
        end else begin
            exp_stall = (lw == 1 && !PCSrcE) ? 1 : 0;
            exp_flush_e = (lw == 1 || PCSrcE) ? 1 : 0;
            check("fwd_a", ForwardAE, fwd(RSD1_E));
            check("fwd_b", ForwardBE, fwd(RSD2_E));
            check("flush_d", FlushD, PCSrcE);
        end
        check("stall_f", StallF, exp_stall);
        check("stall_d", StallD, exp_stall);
        check("flush_e", FlushE, exp_flush_e);
        check("regwrite_w", RegWriteW, m_rw[2]);
        check("resultsrc_w", ResultSrcW, m_rs[2]);
        check("stall_cnt", StallCnt, m_stall_cnt);
        check("flush_cnt", FlushCnt, m_flush_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_rw[i] = 0;
                m_rs[i] = 0;
            end
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            m_stall_cnt = (m_stall_cnt + exp_stall) % CNT_MOD;
            m_flush_cnt = (m_flush_cnt + int'(PCSrcE)) % CNT_MOD;
            m_rw[2] = m_rw[1]; m_rs[2] = m_rs[1];
            m_rw[1] = m_rw[0]; m_rs[1] = m_rs[0];
            m_rw[0] = exp_flush_e ? 0 : int'(RegWriteD);
            m_rs[0] = exp_flush_e ? 0 : int'(ResultSrcD);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        eval_check();
        tick();
        reset = 0;
    endtask

    task automatic step();
        eval_check();
        tick();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        for (int i = 0; i < 3; i++) begin
            m_rw[i] = 0;
            m_rs[i] = 0;
        end
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        exp_stall = 0;
        exp_flush_e = 1;
        reset = 1;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);

        // Reset state
        eval_check();
        check("rst_flush_e", FlushE, 1);
        check("rst_stall_f", StallF, 0);
        tick();
        reset = 0;

        // Two writers then a bubble: M and W both hold RegWrite=1
        RegWriteD = 1; step();
        step();
        RegWriteD = 0; step();
        RdM = 5; RSD1_E = 5; RSD2_E = 0;
        eval_check();
        check("b2b_fwd_a", ForwardAE, 2);
        check("b2b_fwd_b", ForwardBE, 0);
        check("b2b_stall", StallF, 0);
        RdM = 7; RdW = 7; RSD1_E = 0; RSD2_E = 7;
        eval_check();
        check("prio_fwd_b", ForwardBE, 2);
        tick();
        eval_check();
        check("w_only_fwd_b", ForwardBE, 1);
        RSD2_E = 0;
        eval_check();
        check("x0_fwd_b", ForwardBE, 0);
        tick();

        // Load-use: lw x3 enters E, dependent in D, then forwarded from W
        do_reset();
        RegWriteD = 1; ResultSrcD = 2'b01; step();
        RegWriteD = 0; ResultSrcD = 0; RdE = 3; Rs1D = 3;
        cnt_before = int'(StallCnt);
        eval_check();
        check("lu_stall_f", StallF, 1);
        check("lu_flush_e", FlushE, 1);
        tick();
        check("lu_cnt", StallCnt, (cnt_before + 1) % CNT_MOD);
        RdE = 0; RdM = 3;
        eval_check();
        check("lu_release", StallF, 0);
        tick();
        Rs1D = 0; RdM = 0; RdW = 3; RSD1_E = 3;
        eval_check();
        check("lu_fwd_w", ForwardAE, 1);
        tick();

        // Taken branch during load-use
        do_reset();
        RegWriteD = 1; ResultSrcD = 2'b01; step();
        RegWriteD = 0; ResultSrcD = 0; RdE = 4; Rs2D = 4; PCSrcE = 1;
        cnt_before = int'(StallCnt);
        eval_check();
        check("br_stall_f", StallF, 0);
        check("br_flush_d", FlushD, 1);
        check("br_flush_e", FlushE, 1);
        tick();
        check("br_stall_cnt", StallCnt, cnt_before);
        check("br_flush_cnt", FlushCnt, 1);

        // Control latency and flushed bubble
        do_reset();
        RegWriteD = 1; ResultSrcD = 2'b10; step();
        RegWriteD = 0; ResultSrcD = 0; step();
        eval_check();
        check("lat_early", RegWriteW, 0);
        tick();
        eval_check();
        check("lat_rw_w", RegWriteW, 1);
        check("lat_rs_w", ResultSrcW, 2);
        tick();
        RegWriteD = 1; ResultSrcD = 2'b10; PCSrcE = 1; step();
        RegWriteD = 0; ResultSrcD = 0; PCSrcE = 0; step();
        step();
        eval_check();
        check("bubble_rw_w", RegWriteW, 0);
        tick();

        // Counter wrap: 17 stalls in 34 cycles of back-to-back loads
        do_reset();
        RegWriteD = 1; ResultSrcD = 2'b01; RdE = 3; Rs1D = 3;
        for (int i = 0; i < 34; i++) step();
        eval_check();
        check("wrap_stall_cnt", StallCnt, 1);

        // Randomized traffic with occasional mid-run reset
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 39) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            RSD1_E     = 5'($urandom_range(0, 3));
            RSD2_E     = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            RegWriteD  = 1'($urandom_range(0, 1));
            ResultSrcD = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 7) == 0);
            step();
        end

        // Mid-run reset returns everything to reset values after one edge
        reset = 1;
        eval_check();
        tick();
        reset = 0;
        clear_inputs();
        eval_check();
        check("mid_rst_stall_cnt", StallCnt, 0);
        check("mid_rst_flush_cnt", FlushCnt, 0);
        check("mid_rst_rw_w", RegWriteW, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
